trigger_seq: RTL and testbench
==============================

// Module: trigger_seq
// PURPOSE
//  Parametrised N-stage, W-channel sequential trigger for the logic-analyzer core.
//  Each stage does a masked value compare through 4-bit LUT RAMs, serially loaded from mask/value registers.
//  Adds per-stage hit counters and post-match delay; level saturates instead of wrapping.
//  Sits between sampler/demux (data_in, valid_in) and the capture controller (capture, run).
// PARAMETERS
//  WIDTH    32  sampled channel count; multiple of 4 (NLUT = WIDTH/4)
//  STAGES   4   trigger stages, 1..8
//  DLY_W    16  delay counter width, <=16
// PORTS
//  clock        in   1        single clock, all logic rising-edge
//  reset_n      in   1        asynchronous, active-low reset
//  data_in      in   WIDTH    channel sample
//  valid_in     in   1        data_in qualifier
//  wr_mask      in   STAGES   one-hot strobe: config_data -> shared mask reg
//  wr_value     in   STAGES   one-hot strobe: config_data -> shared value reg; starts LUT load of that stage
//  wr_config    in   STAGES   one-hot strobe: config_data -> stage config reg
//  config_data  in   32       host write data (bits above WIDTH ignored)
//  arm          in   1        start acquisition
//  capture      out  1        sticky: arm seen, samples go to FIFO
//  run          out  1        sticky: a start stage fired
//  level        out  LVW      current trigger level, LVW = max(1,$clog2(STAGES))
//  lut_busy     out  1        serial LUT load in progress
// BEHAVIOUR
//  Reset: capture=0, run=0, level=0, lut_busy=0, all counters/configs/mask/value=0. LUT RAM contents are not reset.
//  LUT load: wr_value[s] with lut_busy=0 latches value, sets load_sel=s, lut_busy=1.
//   addr counts 0..15, one write per cycle into all NLUTs of stage s.
//   LUT k, addr a stores ~|((a ^ value[4k+3:4k]) & mask[4k+3:4k]).
//   lut_busy drops the cycle after addr=15 (16 cycles).
//   wr_value during lut_busy: ignored (host polls lut_busy). wr_mask during load: mask updates; load uses live mask (host error, undefined result).
//  Config word: [DLY_W-1:0] delay, [16+LVW-1:16] stage level, [23:20] hitcnt, [27] start.
//  Stage hit: valid_in & capture & (level>=stage level) & all NLUT outputs =1. Stage not yet fired.
//  Stage FSM: IDLE -> COUNT (hits remaining = hitcnt+1) -> DELAY -> FIRED.
//   Each hit decrements remaining. On last hit: delay=0 -> fire next cycle, else enter DELAY.
//   DELAY counts valid_in samples; fires when delay samples have elapsed after the hit.
//   FIRED is sticky until reset_n; wr_config reloads config and returns stage to IDLE.
//  Fire: one-cycle match pulse. If start=1, run<=1 (registered, one cycle after fire).
//  Latency: hit on valid sample at cycle N, hitcnt=0, delay=0 -> match at N+1, run at N+2.
//  level: +1 per cycle when any stage matches (simultaneous matches count once). Saturates at STAGES-1.
//  capture <= capture | arm. Stages ignore data while capture=0.
//  reset_n mid-load: abort, lut_busy=0, partially written LUT; host must reload.
// CONFIGURATION
//  TRIGGER_HITCNT_EN defined: hitcnt field honoured as above.
//  Not defined: hitcnt ignored (treated 0), counter logic removed, config[23:20] reserved.
// STRUCTURE
//  Package trigger_pkg:
//   config field offsets/widths (CFG_DLY_LSB, CFG_LVL_LSB, CFG_HIT_LSB, CFG_START_BIT)
//   stage state encoding (ST_IDLE, ST_COUNT, ST_DELAY, ST_FIRED)
//   LUT_BITS=4
//  Sub-module trigger_stage: LUT array, config reg, hit/delay counters, FSM. Generated STAGES times.
//  Top: mask/value regs, serial load engine, level/capture/run.
// TESTING
//  T1 mask=0xFF, value=0x5A, stage0 level0 start; arm; data 0x5A valid -> match next cycle, run 2 cycles later, level=1.
//  T2 mask=0 -> any valid sample fires; valid_in=0 samples never fire.
//  T3 stage0 delay=3: hit at N, 3 valid samples with gaps -> fire only after 3rd, not on invalid cycles.
//  T4 (TRIGGER_HITCNT_EN) hitcnt=2 -> fires on 3rd matching sample. Undefined build: fires on 1st.
//  T5 stage0 lvl0 / stage1 lvl1 start: stage1 pattern first ignored; after stage0 match, stage1 fires -> run. Both match together -> level+1 only.
//  T6 wr_value, then reset_n low at load cycle 7 -> lut_busy=0 immediately. Second wr_value during busy ignored; lut_busy exactly 16 cycles.

Source files
------------

// File: rtl/trigger_seq_pkg.sv
// trigger_pkg: shared constants and types for the sequential trigger.
// Config word layout, stage FSM encoding and the LUT entry helper.
// Build option TRIGGER_HITCNT_EN (used by trigger_stage) enables hit counting.
package trigger_pkg;

   localparam int LUT_BITS  = 4;
   localparam int LUT_DEPTH = 1 << LUT_BITS;

   // Config word field positions
   localparam int CFG_DLY_LSB   = 0;
   localparam int CFG_LVL_LSB   = 16;
   localparam int CFG_HIT_LSB   = 20;
   localparam int CFG_HIT_W     = 4;
   localparam int CFG_START_BIT = 27;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DELAY = 2'd2,
      ST_FIRED = 2'd3
   } stage_state_t;

   // One LUT bit: address matches value on every bit selected by mask
   function automatic logic lut_entry(input logic [LUT_BITS-1:0] addr,
                                      input logic [LUT_BITS-1:0] value,
                                      input logic [LUT_BITS-1:0] mask);
      return ~|((addr ^ value) & mask);
   endfunction

endpackage

// File: rtl/trigger_seq_stage.sv
// trigger_stage: one stage of the sequential trigger.
// Holds the pattern LUT RAMs, the stage config register, hit/delay counters
// and the IDLE -> COUNT -> DELAY -> FIRED state machine.
// Build option TRIGGER_HITCNT_EN: hitcnt field honoured; otherwise the first hit counts.
module trigger_stage
   import trigger_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DLY_W = 16,
   parameter int LVW   = 2
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [WIDTH-1:0]          data_in,
   input  logic                      valid_in,
   input  logic                      capture,
   input  logic [LVW-1:0]            level,
   input  logic                      lut_we,
   input  logic [LUT_BITS-1:0]       lut_addr,
   input  logic [WIDTH/LUT_BITS-1:0] lut_wdata,
   input  logic                      wr_config,
   input  logic [31:0]               config_data,
   output logic                      match,
   output logic                      start
);
   localparam int NLUT = WIDTH / LUT_BITS;

   logic [NLUT-1:0]  lut_hit;
   logic [DLY_W-1:0] cfg_dly_reg;
   logic [LVW-1:0]   cfg_lvl_reg;
   logic             cfg_start_reg;
   stage_state_t     state_reg, state_next;
   logic [DLY_W-1:0] dly_reg, dly_next;
   logic             match_reg, match_next;
   logic             hit, last_hit;
   logic             unused_cfg;
`ifdef TRIGGER_HITCNT_EN
   logic [CFG_HIT_W-1:0] cfg_hit_reg;
   logic [CFG_HIT_W-1:0] left_reg, left_next;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NLUT; gi++) begin : g_lut
         logic lut_mem [LUT_DEPTH];
         // Serial load port from the top-level engine; contents survive reset
         always_ff @(posedge clock) begin
            if (lut_we) lut_mem[lut_addr] <= lut_wdata[gi];
         end
         // Asynchronous read so a sample is judged in its own cycle
         assign lut_hit[gi] = lut_mem[data_in[gi*LUT_BITS +: LUT_BITS]];
      end
   endgenerate

   // Bits of the host word this stage does not decode
   assign unused_cfg = ^config_data;

   assign hit = valid_in & capture & (level >= cfg_lvl_reg) & (&lut_hit);

   // Config register, rewritten whenever the host strobes this stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cfg_dly_reg   <= '0;
         cfg_lvl_reg   <= '0;
         cfg_start_reg <= 1'b0;
`ifdef TRIGGER_HITCNT_EN
         cfg_hit_reg   <= '0;
`endif
      end else if (wr_config) begin
         cfg_dly_reg   <= config_data[CFG_DLY_LSB +: DLY_W];
         cfg_lvl_reg   <= config_data[CFG_LVL_LSB +: LVW];
         cfg_start_reg <= config_data[CFG_START_BIT];
`ifdef TRIGGER_HITCNT_EN
         cfg_hit_reg   <= config_data[CFG_HIT_LSB +: CFG_HIT_W];
`endif
      end
   end

   // Next-state logic: count hits, then count valid samples, then fire once
   always_comb begin
      state_next = state_reg;
      dly_next   = dly_reg;
      match_next = 1'b0;
      last_hit   = 1'b0;
`ifdef TRIGGER_HITCNT_EN
      left_next  = left_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (hit) begin
`ifdef TRIGGER_HITCNT_EN
               if (cfg_hit_reg == '0) begin
                  last_hit = 1'b1;
               end else begin
                  left_next  = cfg_hit_reg;
                  state_next = ST_COUNT;
               end
`else
               last_hit = 1'b1;
`endif
            end
         end
         ST_COUNT: begin
`ifdef TRIGGER_HITCNT_EN
            if (hit) begin
               if (left_reg == CFG_HIT_W'(1)) last_hit = 1'b1;
               else left_next = left_reg - 1'b1;
            end
`else
            state_next = ST_IDLE;
`endif
         end
         ST_DELAY: begin
            if (valid_in) begin
               if (dly_reg == DLY_W'(1)) begin
                  state_next = ST_FIRED;
                  match_next = 1'b1;
               end else begin
                  dly_next = dly_reg - 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (last_hit) begin
         if (cfg_dly_reg == '0) begin
            state_next = ST_FIRED;
            match_next = 1'b1;
         end else begin
            state_next = ST_DELAY;
            dly_next   = cfg_dly_reg;
         end
      end
      // A config write re-arms the stage regardless of where it was
      if (wr_config) begin
         state_next = ST_IDLE;
         dly_next   = '0;
         match_next = 1'b0;
`ifdef TRIGGER_HITCNT_EN
         left_next  = '0;
`endif
      end
   end

   // State and counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         dly_reg   <= '0;
         match_reg <= 1'b0;
`ifdef TRIGGER_HITCNT_EN
         left_reg  <= '0;
`endif
      end else begin
         state_reg <= state_next;
         dly_reg   <= dly_next;
         match_reg <= match_next;
`ifdef TRIGGER_HITCNT_EN
         left_reg  <= left_next;
`endif
      end
   end

   assign match = match_reg;
   assign start = cfg_start_reg;

endmodule

// File: rtl/trigger_seq.sv
// trigger_seq: N-stage sequential trigger between the sampler and capture controller.
// Owns the shared mask/value registers, the serial LUT load engine and the
// level / capture / run state. Build option TRIGGER_HITCNT_EN enables per-stage hit counts.
module trigger_seq
   import trigger_pkg::*;
#(
   parameter int  WIDTH  = 32,
   parameter int  STAGES = 4,
   parameter int  DLY_W  = 16,
   localparam int LVW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              valid_in,
   input  logic [STAGES-1:0] wr_mask,
   input  logic [STAGES-1:0] wr_value,
   input  logic [STAGES-1:0] wr_config,
   input  logic [31:0]       config_data,
   input  logic              arm,
   output logic              capture,
   output logic              run,
   output logic [LVW-1:0]    level,
   output logic              lut_busy
);
   localparam int             NLUT    = WIDTH / LUT_BITS;
   localparam logic [LVW-1:0] LVL_MAX = LVW'(STAGES - 1);

   logic [WIDTH-1:0]    mask_reg, value_reg;
   logic                busy_reg;
   logic [LUT_BITS-1:0] addr_reg;
   logic [LVW-1:0]      sel_reg, wr_sel;
   logic [NLUT-1:0]     lut_wdata;
   logic [STAGES-1:0]   match_vec, start_vec;
   logic                capture_reg, run_reg;
   logic [LVW-1:0]      level_reg;

   // Encode the one-hot value strobe into a stage index
   always_comb begin
      wr_sel = '0;
      for (int s = 0; s < STAGES; s++) begin
         if (wr_value[s]) wr_sel = LVW'(s);
      end
   end

   // Shared mask register; the load engine reads it live
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) mask_reg <= '0;
      else if (|wr_mask) mask_reg <= config_data[WIDTH-1:0];
   end

   // Serial load engine: 16 address steps into the selected stage; new requests ignored while busy
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         value_reg <= '0;
         busy_reg  <= 1'b0;
         addr_reg  <= '0;
         sel_reg   <= '0;
      end else if (busy_reg) begin
         addr_reg <= addr_reg + 1'b1;
         if (addr_reg == '1) busy_reg <= 1'b0;
      end else if (|wr_value) begin
         value_reg <= config_data[WIDTH-1:0];
         sel_reg   <= wr_sel;
         busy_reg  <= 1'b1;
         addr_reg  <= '0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NLUT; gi++) begin : g_wdata
         assign lut_wdata[gi] = lut_entry(addr_reg,
                                          value_reg[gi*LUT_BITS +: LUT_BITS],
                                          mask_reg[gi*LUT_BITS +: LUT_BITS]);
      end

      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         trigger_stage #(
            .WIDTH (WIDTH),
            .DLY_W (DLY_W),
            .LVW   (LVW)
         ) u_stage (
            .clock       (clock),
            .reset_n     (reset_n),
            .data_in     (data_in),
            .valid_in    (valid_in),
            .capture     (capture_reg),
            .level       (level_reg),
            .lut_we      (busy_reg && (sel_reg == LVW'(gi))),
            .lut_addr    (addr_reg),
            .lut_wdata   (lut_wdata),
            .wr_config   (wr_config[gi]),
            .config_data (config_data),
            .match       (match_vec[gi]),
            .start       (start_vec[gi])
         );
      end
   endgenerate

   // Sticky capture/run and saturating level; simultaneous matches advance level once
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         capture_reg <= 1'b0;
         run_reg     <= 1'b0;
         level_reg   <= '0;
      end else begin
         capture_reg <= capture_reg | arm;
         run_reg     <= run_reg | (|(match_vec & start_vec));
         if ((|match_vec) && (level_reg != LVL_MAX)) level_reg <= level_reg + 1'b1;
      end
   end

   assign capture  = capture_reg;
   assign run      = run_reg;
   assign level    = level_reg;
   assign lut_busy = busy_reg;

endmodule

// File: tb/tb_trigger_seq.sv
// tb_trigger_seq: directed and randomized bench for trigger_seq.
// A behavioural model (pattern compare by arithmetic, hit/delay bookkeeping
// in integers) predicts capture/run/level/lut_busy every cycle.
// Honours TRIGGER_HITCNT_EN the same way as the design.
`timescale 1ns/1ps
module tb_trigger_seq;
   localparam int WIDTH  = 32;
   localparam int STAGES = 4;
   localparam int DLY_W  = 16;
   localparam int LVW    = 2;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [WIDTH-1:0]  data_in;
   logic              valid_in;
   logic [STAGES-1:0] wr_mask, wr_value, wr_config;
   logic [31:0]       config_data;
   logic              arm;
   logic              capture, run, lut_busy;
   logic [LVW-1:0]    level;

   trigger_seq #(.WIDTH(WIDTH), .STAGES(STAGES), .DLY_W(DLY_W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .wr_mask     (wr_mask),
      .wr_value    (wr_value),
      .wr_config   (wr_config),
      .config_data (config_data),
      .arm         (arm),
      .capture     (capture),
      .run         (run),
      .level       (level),
      .lut_busy    (lut_busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [31:0] pat_val  [STAGES];
   logic [31:0] pat_mask [STAGES];
   logic [31:0] m_mask;
   int  cfg_lvl [STAGES], cfg_dly [STAGES], cfg_hits [STAGES];
   bit  cfg_start [STAGES];
   int  need [STAGES], dleft [STAGES];
   bit  waiting [STAGES], fired [STAGES], m_match [STAGES];
   bit  m_cap, m_run;
   int  m_level, m_busy;

   task automatic model_reset();
      m_cap = 0; m_run = 0; m_level = 0; m_busy = 0; m_mask = '0;
      for (int s = 0; s < STAGES; s++) begin
         cfg_lvl[s] = 0; cfg_dly[s] = 0; cfg_hits[s] = 1; cfg_start[s] = 0;
         need[s] = 1; dleft[s] = 0; waiting[s] = 0; fired[s] = 0; m_match[s] = 0;
      end
   endtask

   // One rising edge worth of behaviour, using the inputs as sampled at that edge
   task automatic model_step();
      bit any_old = 0;
      bit run_old = 0;
      bit new_match [STAGES];
      for (int s = 0; s < STAGES; s++) begin
         if (m_match[s]) begin
            any_old = 1;
            if (cfg_start[s]) run_old = 1;
         end
      end
      for (int s = 0; s < STAGES; s++) begin
         new_match[s] = 0;
         if (wr_config[s]) begin
            cfg_dly[s]   = int'(config_data[15:0]);
            cfg_lvl[s]   = int'(config_data[17:16]);
`ifdef TRIGGER_HITCNT_EN
            cfg_hits[s]  = int'(config_data[23:20]) + 1;
`else
            cfg_hits[s]  = 1;
`endif
            cfg_start[s] = config_data[27];
            need[s] = cfg_hits[s]; waiting[s] = 0; fired[s] = 0;
         end else if (fired[s]) begin
            new_match[s] = 0;
         end else if (waiting[s]) begin
            if (valid_in) begin
               dleft[s]--;
               if (dleft[s] == 0) begin fired[s] = 1; new_match[s] = 1; end
            end
         end else if (valid_in && m_cap && (m_level >= cfg_lvl[s]) &&
                      (((data_in ^ pat_val[s]) & pat_mask[s]) == 32'd0)) begin
            need[s]--;
            if (need[s] == 0) begin
               if (cfg_dly[s] == 0) begin fired[s] = 1; new_match[s] = 1; end
               else begin waiting[s] = 1; dleft[s] = cfg_dly[s]; end
            end
         end
      end
      if (any_old && m_level < STAGES - 1) m_level++;
      if (run_old) m_run = 1;
      if (arm) m_cap = 1;
      for (int s = 0; s < STAGES; s++) m_match[s] = new_match[s];
      if (m_busy > 0) begin
         m_busy--;
      end else if (wr_value != '0) begin
         for (int s = 0; s < STAGES; s++) begin
            if (wr_value[s]) begin
               pat_val[s]  = config_data;
               pat_mask[s] = m_mask;
            end
         end
         m_busy = 16;
      end
      if (wr_mask != '0) m_mask = config_data;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
      check("capture",  32'(capture),  32'(m_cap));
      check("run",      32'(run),      32'(m_run));
      check("level",    32'(level),    32'(m_level));
      check("lut_busy", 32'(lut_busy), 32'(m_busy > 0));
   endtask

   task automatic drive_idle();
      data_in = '0; valid_in = 0; wr_mask = '0; wr_value = '0; wr_config = '0;
      config_data = '0; arm = 0;
   endtask

   task automatic do_reset();
      drive_idle();
      reset_n = 0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1;
      check("rst_capture", 32'(capture), 32'd0);
      check("rst_run",     32'(run),     32'd0);
      check("rst_level",   32'(level),   32'd0);
      check("rst_busy",    32'(lut_busy), 32'd0);
   endtask

   task automatic load_stage(input int s, input logic [31:0] mk, input logic [31:0] vl);
      config_data = mk;  wr_mask  = STAGES'(1 << s); tick(); wr_mask  = '0;
      config_data = vl;  wr_value = STAGES'(1 << s); tick(); wr_value = '0;
      config_data = '0;
      repeat (16) tick();
      $display("load stage %0d mask=%08h value=%08h", s, mk, vl);
   endtask

   task automatic config_stage(input int s, input int lvl, input int dly, input int hits, input bit st);
      config_data = (32'(st) << 27) | (32'(hits & 15) << 20) | (32'(lvl & 3) << 16) | 32'(dly & 16'hFFFF);
      wr_config = STAGES'(1 << s);
      tick();
      wr_config = '0; config_data = '0;
      $display("config stage %0d lvl=%0d dly=%0d hitcnt=%0d start=%0d", s, lvl, dly, hits, st);
   endtask

   task automatic send(input logic [31:0] d, input logic v);
      data_in = d; valid_in = v;
      tick();
      data_in = '0; valid_in = 0;
   endtask

   task automatic do_arm();
      arm = 1; tick(); arm = 0;
   endtask

   logic [31:0] r_mask, r_val;
   int          busy_cnt;

   initial begin
      drive_idle();
      model_reset();
      for (int s = 0; s < STAGES; s++) begin pat_val[s] = '0; pat_mask[s] = '0; end

      // T1: basic match, latency to match/run/level
      do_reset();
      for (int s = 1; s < STAGES; s++) load_stage(s, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      load_stage(0, 32'h0000_00FF, 32'h0000_005A);
      config_stage(0, 0, 0, 0, 1);
      do_arm();
      send(($urandom & 32'hFFFF_FF00) | 32'h5A, 1);
      check("t1_run_early", 32'(run), 32'd0);
      tick();
      check("t1_run",   32'(run),   32'd1);
      check("t1_level", 32'(level), 32'd1);
      $display("T1 pattern 0x5A: run=%0d level=%0d", run, level);

      // T2: mask=0 fires on any valid sample only
      do_reset();
      load_stage(0, 32'h0, $urandom);
      config_stage(0, 0, 0, 0, 1);
      do_arm();
      for (int i = 0; i < 5; i++) send($urandom & 32'h7FFF_FFFF, 0);
      check("t2_invalid_no_run", 32'(run), 32'd0);
      send($urandom & 32'h7FFF_FFFF, 1);
      tick();
      check("t2_run", 32'(run), 32'd1);
      $display("T2 mask zero: run=%0d", run);

      // T3: delay of 3 valid samples with gaps
      do_reset();
      load_stage(0, 32'h0000_00FF, 32'h0000_005A);
      config_stage(0, 0, 3, 0, 1);
      do_arm();
      send(32'h5A, 1);
      send($urandom & 32'h7FFF_FFFF, 0);
      send($urandom & 32'h7FFF_FFFF, 1);
      send($urandom & 32'h7FFF_FFFF, 0);
      send($urandom & 32'h7FFF_FFFF, 0);
      send($urandom & 32'h7FFF_FFFF, 1);
      send($urandom & 32'h7FFF_FFFF, 0);
      tick();
      check("t3_run_before_third", 32'(run), 32'd0);
      send($urandom & 32'h7FFF_FFFF, 1);
      check("t3_run_match_cycle", 32'(run), 32'd0);
      tick();
      check("t3_run", 32'(run), 32'd1);
      $display("T3 delay 3: run=%0d", run);

      // T4: hitcnt=2
      do_reset();
      load_stage(0, 32'h0000_00FF, 32'h0000_005A);
      config_stage(0, 0, 0, 2, 1);
      do_arm();
      send(32'h1234_565A, 1);
      tick();
`ifdef TRIGGER_HITCNT_EN
      check("t4_first_hit", 32'(run), 32'd0);
`else
      check("t4_first_hit", 32'(run), 32'd1);
`endif
      send(32'h0000_005A, 1);
      send(32'h0000_0000, 1);
      send(32'hABCD_EF5A, 1);
      tick();
      check("t4_third_hit", 32'(run), 32'd1);
      $display("T4 hitcnt 2: run=%0d", run);

      // T5a: stage1 needs level 1, reached only after stage0
      do_reset();
      load_stage(0, 32'h0000_00FF, 32'h0000_0011);
      load_stage(1, 32'h0000_00FF, 32'h0000_0022);
      config_stage(0, 0, 0, 0, 0);
      config_stage(1, 1, 0, 0, 1);
      do_arm();
      send(32'h22, 1);
      tick();
      check("t5_early_level", 32'(level), 32'd0);
      check("t5_early_run",   32'(run),   32'd0);
      send(32'h11, 1);
      tick();
      check("t5_stage0_level", 32'(level), 32'd1);
      check("t5_stage0_run",   32'(run),   32'd0);
      send(32'h22, 1);
      tick();
      check("t5_stage1_level", 32'(level), 32'd2);
      check("t5_stage1_run",   32'(run),   32'd1);
      $display("T5a sequence: level=%0d run=%0d", level, run);

      // T5b: two stages matching together advance level once
      do_reset();
      load_stage(1, 32'h0000_00FF, 32'h0000_0011);
      config_stage(0, 0, 0, 0, 0);
      config_stage(1, 0, 0, 0, 1);
      do_arm();
      send(32'h11, 1);
      tick();
      check("t5_both_level", 32'(level), 32'd1);
      check("t5_both_run",   32'(run),   32'd1);
      $display("T5b simultaneous: level=%0d run=%0d", level, run);

      // Randomized rounds with all stages configured
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int s = 0; s < STAGES; s++) begin
            r_mask = 32'($urandom_range(0, 15)) << (4 * $urandom_range(0, 7));
            r_val  = $urandom;
            load_stage(s, r_mask, r_val);
         end
         for (int s = 0; s < STAGES; s++)
            config_stage(s, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         do_arm();
         for (int i = 0; i < 150; i++) send($urandom, ($urandom_range(0, 9) < 7));
         $display("random round %0d: level=%0d run=%0d", r, level, run);
      end

      // T6: reset aborts a load; busy window is exactly 16 cycles
      do_reset();
      config_data = $urandom; wr_value = 4'b0001; tick(); wr_value = '0;
      repeat (7) tick();
      reset_n = 0;
      #1;
      check("t6_abort_busy", 32'(lut_busy), 32'd0);
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1;
      config_data = $urandom; wr_value = 4'b0001; tick(); wr_value = '0;
      busy_cnt = lut_busy ? 1 : 0;
      for (int i = 0; i < 25; i++) begin
         if (i == 4) begin config_data = $urandom; wr_value = 4'b0100; end
         else wr_value = '0;
         tick();
         if (lut_busy) busy_cnt++;
      end
      check("t6_busy_len", 32'(busy_cnt), 32'd16);
      $display("T6 load abort and busy window: busy cycles=%0d", busy_cnt);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
